// File: rtl/zero_run_decoder.sv
// Zero-run token expander: each token n becomes n zeros plus a terminating one, or DATA_WIDTH zeros with no one.
// Optional sticky out-of-range flag `err` is built when the ZRD_ERR_EN macro is defined.
module zero_run_decoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [$clog2(DATA_WIDTH):0]     din,
  input  logic                            din_valid,
  output logic                            din_ready,
  output logic                            dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            dout_last
`ifdef ZRD_ERR_EN
  ,
  output logic                            err
`endif
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] DW_C  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    ONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          term_q, term_d;
  logic          dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;

  logic          hs;
  logic          last_hs;
  logic          accept;
  logic [CW-1:0] tok;

  assign hs        = dout_valid_q & dout_ready;
  assign last_hs   = hs & dout_last_q;
  assign din_ready = (state_q == IDLE) | last_hs;
  assign accept    = din_valid & din_ready;
  assign tok       = (din > DW_C) ? DW_C : din;

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      term_q       <= 1'b0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      term_q       <= term_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  // A token can only be accepted in IDLE or on the last handshake, so it overrides the drain path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    term_d  = term_q;
    case (state_q)
      ZEROS: begin
        if (hs) begin
          if (cnt_q != ONE_C) begin
            cnt_d = cnt_q - ONE_C;
          end else if (term_q) begin
            state_d = ONE;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      ONE: begin
        if (hs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      term_d  = (tok != DW_C);
      cnt_d   = tok;
      state_d = (tok == '0) ? ONE : ZEROS;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    dout_valid_d = (state_d != IDLE);
    dout_d       = (state_d == ONE);
    dout_last_d  = (state_d == ONE) |
                   ((state_d == ZEROS) & (cnt_d == ONE_C) & ~term_d);
  end

`ifdef ZRD_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (accept && (din > DW_C)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_zero_run_decoder.sv
// Bench for zero_run_decoder: expected bit queue built from tokens, checked every cycle, plus literal scenarios.
module tb_zero_run_decoder;
  localparam int DW = 32;
  localparam int CW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [CW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
`ifdef ZRD_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  zero_run_decoder #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
`ifdef ZRD_ERR_EN
    ,
    .err        (err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] exp_q[$];   // {bit, last}
  logic       got_q[$];
  logic       got_last_q[$];
  logic       err_exp = 1'b0;

  bit            pend_hs;
  bit            pend_acc;
  logic [CW-1:0] pend_n;
  logic          pend_bit;
  logic          pend_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic void push_token(input int n);
    int m;
    m = (n > DW) ? DW : n;
    for (int i = 0; i < m; i++) exp_q.push_back({1'b0, (i == m - 1) && (m == DW)});
    if (m < DW) exp_q.push_back(2'b11);
  endfunction

  always @(negedge clk) begin
    pend_hs  = 1'b0;
    pend_acc = 1'b0;
    if (resetn) begin
      check("dout_valid", dout_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("dout", dout, exp_q[0][1]);
        check("dout_last", dout_last, exp_q[0][0]);
      end
      check("din_ready", din_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && dout_ready));
`ifdef ZRD_ERR_EN
      check("err", err, err_exp);
`endif
      pend_hs   = dout_valid && dout_ready;
      pend_bit  = dout;
      pend_last = dout_last;
      pend_acc  = din_valid && din_ready;
      pend_n    = din;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      if (pend_hs) begin
        got_q.push_back(pend_bit);
        got_last_q.push_back(pend_last);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (pend_acc) begin
        push_token(int'(pend_n));
        if (int'(pend_n) > DW) err_exp = 1'b1;
      end
    end
  end

  task automatic send(input int n);
    int t;
    t = 0;
    din = CW'(n);
    din_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (din_ready) break;
      t++;
      if (t > 300) begin
        timeout_fail("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    dout_ready = 1'b1;
    while ((exp_q.size() != 0 || dout_valid) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 1000) timeout_fail("drain");
  endtask

  task automatic check_all_zero_run(input int base, input string tag);
    int ones;
    int lasts;
    ones = 0;
    lasts = 0;
    check({tag, "_len"}, got_q.size() - base, 32);
    for (int i = 0; i < 32 && base + i < got_q.size(); i++) begin
      ones += int'(got_q[base + i]);
      lasts += int'(got_last_q[base + i]);
    end
    check({tag, "_ones"}, ones, 0);
    check({tag, "_lasts"}, lasts, 1);
    if (got_q.size() >= base + 32) check({tag, "_last_pos"}, got_last_q[base + 31], 1'b1);
  endtask

  initial begin
    int base;
    int c0;
    int t;
    bit acc;
    logic [4:0] pat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout", dout, 1'b0);
    check("rst_dout_last", dout_last, 1'b0);
    check("rst_din_ready", din_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    dout_ready = 1'b1;

    // Idle with no tokens
    repeat (20) @(posedge clk);
    #1;
    check("idle_dout_valid", dout_valid, 1'b0);
    check("idle_din_ready", din_ready, 1'b1);

    // n=0 then n=3 back-to-back
    base = got_q.size();
    send(0);
    c0 = cyc;
    send(3);
    t = 0;
    while (got_q.size() < base + 5 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) timeout_fail("b2b_bits");
    check("b2b_cycles", cyc - c0, 5);
    pat = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      if (base + i < got_q.size()) begin
        check("b2b_bit", got_q[base + i], pat[4 - i]);
        check("b2b_last", got_last_q[base + i], pat[4 - i]);
      end
    end
    drain();

    // n=32 all-zero run, next token accepted on its last bit
    base = got_q.size();
    send(32);
    c0 = cyc;
    send(5);
    check("n32_next_accept", cyc - c0, 32);
    check_all_zero_run(base, "n32");
    drain();
    check("n5_len", got_q.size() - base, 38);

    // n=2 with backpressure 1,0,0,1,1
    base = got_q.size();
    send(2);
    @(posedge clk); #1; dout_ready = 1'b0;
    @(posedge clk); #1; dout_ready = 1'b0;
    @(posedge clk); #1; dout_ready = 1'b1;
    @(posedge clk); #1; dout_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_len", got_q.size() - base, 3);
    if (got_q.size() >= base + 3) begin
      check("stall_b0", got_q[base], 1'b0);
      check("stall_b1", got_q[base + 1], 1'b0);
      check("stall_b2", got_q[base + 2], 1'b1);
      check("stall_last", {got_last_q[base], got_last_q[base + 1], got_last_q[base + 2]}, 3'b001);
    end
    drain();

    // n=40 is clamped to 32
    base = got_q.size();
    send(40);
`ifdef ZRD_ERR_EN
    check("err_after_accept", err, 1'b1);
`endif
    drain();
    check_all_zero_run(base, "n40");
`ifdef ZRD_ERR_EN
    check("err_sticky", err, 1'b1);
`endif

    // Reset in the middle of an n=20 token
    send(20);
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_dout_valid", dout_valid, 1'b0);
    check("midrst_dout", dout, 1'b0);
    check("midrst_dout_last", dout_last, 1'b0);
    check("midrst_din_ready", din_ready, 1'b1);
`ifdef ZRD_ERR_EN
    check("midrst_err", err, 1'b0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b1;
    base = got_q.size();
    repeat (5) @(posedge clk);
    #1;
    check("postrst_no_bits", got_q.size() - base, 0);
    check("postrst_din_ready", din_ready, 1'b1);
    send(1);
    drain();
    check("postrst_len", got_q.size() - base, 2);
    if (got_q.size() >= base + 2) begin
      check("postrst_bits", {got_q[base], got_q[base + 1]}, 2'b01);
      check("postrst_last", {got_last_q[base], got_last_q[base + 1]}, 2'b01);
    end

    // Randomized tokens and backpressure
    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk);
      #1;
      if (acc) din_valid = 1'b0;
      if (!din_valid && $urandom_range(0, 3) != 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 2)      din = CW'($urandom_range(0, 3));
        else if (r < 7) din = CW'($urandom_range(0, 31));
        else if (r < 9) din = CW'(32);
        else            din = CW'($urandom_range(33, 63));
        din_valid = 1'b1;
      end
      dout_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    acc = din_valid && din_ready;
    @(posedge clk);
    #1;
    if (acc) din_valid = 1'b0;
    if (din_valid) begin
      dout_ready = 1'b1;
      t = 0;
      while (din_valid && t < 100) begin
        @(negedge clk);
        acc = din_ready;
        @(posedge clk);
        #1;
        if (acc) din_valid = 1'b0;
        t++;
      end
      if (t >= 100) timeout_fail("final_accept");
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("end_idle", dout_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
